// File: rtl/crc32_stream.sv
// Streaming CRC-32 (poly 0x04C11DB7, MSB-first) over 4- or 8-bit beats.
// CHECK mode passes frames through and judges the FCS; GENERATE mode appends it.
module crc32_stream #(
    parameter int          DATA_W  = 4,
    parameter bit          MODE    = 1'b0,
    parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
    parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] axiid,
    input  logic              axiiv,
    input  logic              axiil,
    output logic              axiir,
    output logic [DATA_W-1:0] axiod,
    output logic              axiov,
    output logic              axiol,
    input  logic              axior,
    input  logic              stat_clr,
    output logic [31:0]       crc_o,
    output logic              crc_done,
    output logic              crc_ok,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt,
    output logic [1:0]        dbg_state_o
);

    if (DATA_W != 4 && DATA_W != 8) begin : g_bad_width
        $error("crc32_stream: DATA_W must be 4 or 8");
    end

    localparam logic [31:0] POLY     = 32'h04C1_1DB7;
    localparam logic [2:0]  LAST_CNT = 3'(32 / DATA_W - 1);

    // Handshake: a beat moves on a port only in a cycle where its valid and ready are both high.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_FCS = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d, lfsr_next;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_q, fcs_d, fcs_sh;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] err_q, err_d;
    logic        in_fire, out_fire;

    assign in_fire  = axiiv && axiir;
    assign out_fire = axiov && axior;

    always_comb begin
        lfsr_next = lfsr_q;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            lfsr_next = {lfsr_next[30:0], 1'b0} ^ ((lfsr_next[31] ^ axiid[i]) ? POLY : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DATA: begin
                if (in_fire) begin
                    if (axiil) state_d = MODE ? S_FCS : S_IDLE;
                    else       state_d = S_DATA;
                end
            end
            S_FCS: begin
                if (out_fire && cnt_q == LAST_CNT) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fcs_sh = fcs_q << (32'(cnt_q) * DATA_W);
        axiod  = axiid;
        axiov  = axiiv;
        axiir  = axior;
        axiol  = MODE ? 1'b0 : axiil;
        if (state_q == S_FCS) begin
            axiod = fcs_sh[31 -: DATA_W];
            axiov = 1'b1;
            axiir = 1'b0;
            axiol = (cnt_q == LAST_CNT);
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        crc_d  = crc_q;
        fcs_d  = fcs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        ok_d   = ok_q;
        if (state_q != S_FCS && in_fire) begin
            lfsr_d = lfsr_next;
            crc_d  = ~lfsr_next;
            if (axiil) begin
                if (MODE) begin
                    fcs_d = ~lfsr_next;
                    cnt_d = 3'd0;
                end else begin
                    done_d = 1'b1;
                    ok_d   = (lfsr_next == RESIDUE);
                    lfsr_d = INIT;
                end
            end
        end
        if (state_q == S_FCS && out_fire) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST_CNT) begin
                done_d = 1'b1;
                ok_d   = 1'b1;
                lfsr_d = INIT;
                cnt_d  = 3'd0;
            end
        end
    end

    // Clear beats a same-cycle increment so software sees a clean zero.
    always_comb begin
        frame_d = frame_q;
        err_d   = err_q;
        if (stat_clr) begin
            frame_d = 16'h0;
            err_d   = 16'h0;
        end else if (done_q) begin
            if (frame_q != 16'hFFFF) frame_d = frame_q + 16'h1;
            if (!MODE && !ok_q && err_q != 16'hFFFF) err_d = err_q + 16'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= INIT;
            crc_q   <= 32'h0;
            fcs_q   <= 32'h0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            frame_q <= 16'h0;
            err_q   <= 16'h0;
        end else begin
            lfsr_q  <= lfsr_d;
            crc_q   <= crc_d;
            fcs_q   <= fcs_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign crc_o       = crc_q;
    assign crc_done    = done_q;
    assign crc_ok      = ok_q;
    assign frame_cnt   = frame_q;
    assign err_cnt     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: GENERATE at 8 and 4 bits, CHECK at 8 bits,
// with a per-instance expected-beat queue checked as beats leave the DUT.
module tb_crc32_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [31:0] fcs_ref = 32'hFC89_1918;
    logic        bp_on = 1'b0;

    // GENERATE, 8-bit
    logic [7:0]  id_g8 = '0, od_g8;
    logic        iv_g8 = 0, il_g8 = 0, ir_g8, ov_g8, ol_g8, or_g8 = 0, clr_g8 = 0, done_g8, ok_g8;
    logic [31:0] crc_g8;
    logic [15:0] fcnt_g8, ecnt_g8;
    logic [1:0]  st_g8;
    // GENERATE, 4-bit
    logic [3:0]  id_g4 = '0, od_g4;
    logic        iv_g4 = 0, il_g4 = 0, ir_g4, ov_g4, ol_g4, or_g4 = 0, clr_g4 = 0, done_g4, ok_g4;
    logic [31:0] crc_g4;
    logic [15:0] fcnt_g4, ecnt_g4;
    logic [1:0]  st_g4;
    // CHECK, 8-bit
    logic [7:0]  id_c8 = '0, od_c8;
    logic        iv_c8 = 0, il_c8 = 0, ir_c8, ov_c8, ol_c8, or_c8 = 0, clr_c8 = 0, done_c8, ok_c8;
    logic [31:0] crc_c8;
    logic [15:0] fcnt_c8, ecnt_c8;
    logic [1:0]  st_c8;

    crc32_stream #(.DATA_W(8), .MODE(1'b1)) u_g8 (
        .clk(clk), .rst_n(rst_n), .axiid(id_g8), .axiiv(iv_g8), .axiil(il_g8), .axiir(ir_g8),
        .axiod(od_g8), .axiov(ov_g8), .axiol(ol_g8), .axior(or_g8), .stat_clr(clr_g8),
        .crc_o(crc_g8), .crc_done(done_g8), .crc_ok(ok_g8), .frame_cnt(fcnt_g8),
        .err_cnt(ecnt_g8), .dbg_state_o(st_g8));

    crc32_stream #(.DATA_W(4), .MODE(1'b1)) u_g4 (
        .clk(clk), .rst_n(rst_n), .axiid(id_g4), .axiiv(iv_g4), .axiil(il_g4), .axiir(ir_g4),
        .axiod(od_g4), .axiov(ov_g4), .axiol(ol_g4), .axior(or_g4), .stat_clr(clr_g4),
        .crc_o(crc_g4), .crc_done(done_g4), .crc_ok(ok_g4), .frame_cnt(fcnt_g4),
        .err_cnt(ecnt_g4), .dbg_state_o(st_g4));

    crc32_stream #(.DATA_W(8), .MODE(1'b0)) u_c8 (
        .clk(clk), .rst_n(rst_n), .axiid(id_c8), .axiiv(iv_c8), .axiil(il_c8), .axiir(ir_c8),
        .axiod(od_c8), .axiov(ov_c8), .axiol(ol_c8), .axior(or_c8), .stat_clr(clr_c8),
        .crc_o(crc_c8), .crc_done(done_c8), .crc_ok(ok_c8), .frame_cnt(fcnt_c8),
        .err_cnt(ecnt_c8), .dbg_state_o(st_c8));

    logic [8:0] exp_g8[$];
    logic [4:0] exp_g4[$];
    logic [8:0] exp_c8[$];
    logic [8:0] e_g8, e_c8;
    logic [4:0] e_g4;
    int dn_g8 = 0, dn_g4 = 0, dn_c8 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboards: sampled on the falling edge, the beat is taken at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && ov_g8 && or_g8) begin
            check("g8_sb_nonempty", 32'(exp_g8.size() != 0), 32'd1);
            if (exp_g8.size() != 0) begin
                e_g8 = exp_g8.pop_front();
                check("g8_beat", {23'd0, ol_g8, od_g8}, {23'd0, e_g8});
            end
        end
        if (rst_n && ov_g4 && or_g4) begin
            check("g4_sb_nonempty", 32'(exp_g4.size() != 0), 32'd1);
            if (exp_g4.size() != 0) begin
                e_g4 = exp_g4.pop_front();
                check("g4_beat", {27'd0, ol_g4, od_g4}, {27'd0, e_g4});
            end
        end
        if (rst_n && ov_c8 && or_c8) begin
            check("c8_sb_nonempty", 32'(exp_c8.size() != 0), 32'd1);
            if (exp_c8.size() != 0) begin
                e_c8 = exp_c8.pop_front();
                check("c8_beat", {23'd0, ol_c8, od_c8}, {23'd0, e_c8});
            end
        end
        if (rst_n && done_g8) dn_g8++;
        if (rst_n && done_g4) dn_g4++;
        if (rst_n && done_c8) dn_c8++;
    end

    function automatic logic ready_of(input int which);
        return (which == 0) ? ir_g8 : (which == 1) ? ir_g4 : ir_c8;
    endfunction

    // Entered and left at posedge+1; holds valid until the beat is accepted.
    task automatic send(input int which, input logic [7:0] d, input logic l);
        int   t;
        logic rdy;
        t = 0;
        case (which)
            0:       begin iv_g8 = 1'b1; id_g8 = d;      il_g8 = l; end
            1:       begin iv_g4 = 1'b1; id_g4 = d[3:0]; il_g4 = l; end
            default: begin iv_c8 = 1'b1; id_c8 = d;      il_c8 = l; end
        endcase
        @(negedge clk);
        rdy = ready_of(which);
        while (!rdy && t < 200) begin
            @(negedge clk);
            t++;
            rdy = ready_of(which);
        end
        check("send_ready_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        case (which)
            0:       begin iv_g8 = 1'b0; il_g8 = 1'b0; end
            1:       begin iv_g4 = 1'b0; il_g4 = 1'b0; end
            default: begin iv_c8 = 1'b0; il_c8 = 1'b0; end
        endcase
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_g8.size() + exp_g4.size() + exp_c8.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_g8.size() + exp_g4.size() + exp_c8.size()), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic gen8_frame();
        for (int i = 0; i < 9; i++) exp_g8.push_back({1'b0, msg[i]});
        for (int k = 0; k < 4; k++) exp_g8.push_back({k == 3, fcs_ref[31-8*k -: 8]});
        for (int i = 0; i < 9; i++) send(0, msg[i], i == 8);
    endtask

    task automatic gen4_frame();
        logic [7:0] n;
        for (int i = 0; i < 18; i++) begin
            n = (i % 2 == 0) ? {4'h0, msg[i/2][7:4]} : {4'h0, msg[i/2][3:0]};
            exp_g4.push_back({1'b0, n[3:0]});
        end
        for (int k = 0; k < 8; k++) exp_g4.push_back({k == 7, fcs_ref[31-4*k -: 4]});
        for (int i = 0; i < 18; i++) begin
            n = (i % 2 == 0) ? {4'h0, msg[i/2][7:4]} : {4'h0, msg[i/2][3:0]};
            send(1, n, i == 17);
        end
    endtask

    task automatic chk8_frame(input logic [7:0] first);
        logic [7:0] fr [13];
        for (int i = 0; i < 13; i++) fr[i] = (i < 9) ? msg[i] : fcs_ref[31-8*(i-9) -: 8];
        fr[0] = first;
        for (int i = 0; i < 13; i++) exp_c8.push_back({i == 12, fr[i]});
        for (int i = 0; i < 13; i++) send(2, fr[i], i == 12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // Reset state
        #2;
        check("rst_crc_o", crc_g8, 32'h0);
        check("rst_done", {31'd0, done_g8}, 32'd0);
        check("rst_ok", {31'd0, ok_c8}, 32'd0);
        check("rst_fcnt", {16'd0, fcnt_c8}, 32'd0);
        check("rst_ecnt", {16'd0, ecnt_c8}, 32'd0);
        check("rst_ov", {31'd0, ov_g8}, 32'd0);
        check("rst_ir_follows_or_lo", {31'd0, ir_c8}, 32'd0);
        or_g8 = 1'b1; or_g4 = 1'b1; or_c8 = 1'b1;
        #1;
        check("rst_ir_follows_or_hi", {31'd0, ir_c8}, 32'd1);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: GENERATE 8-bit "123456789"
        gen8_frame();
        wait_drain();
        check("g8_crc_o", crc_g8, fcs_ref);
        check("g8_done_once", 32'(dn_g8), 32'd1);
        check("g8_frame_cnt", {16'd0, fcnt_g8}, 32'd1);
        check("g8_ok", {31'd0, ok_g8}, 32'd1);
        check("g8_err_cnt", {16'd0, ecnt_g8}, 32'd0);

        // 2: GENERATE 4-bit, nibbles high-first
        gen4_frame();
        wait_drain();
        check("g4_crc_o", crc_g4, fcs_ref);
        check("g4_done_once", 32'(dn_g4), 32'd1);
        check("g4_frame_cnt", {16'd0, fcnt_g4}, 32'd1);

        // 3: CHECK 8-bit, good frame then a single flipped data bit
        chk8_frame(8'h31);
        wait_drain();
        check("c8_good_ok", {31'd0, ok_c8}, 32'd1);
        check("c8_good_crc_o", crc_c8, 32'h38FB_2284);
        check("c8_good_err", {16'd0, ecnt_c8}, 32'd0);
        check("c8_good_fcnt", {16'd0, fcnt_c8}, 32'd1);
        chk8_frame(8'h30);
        wait_drain();
        check("c8_bad_ok", {31'd0, ok_c8}, 32'd0);
        check("c8_bad_err", {16'd0, ecnt_c8}, 32'd1);
        check("c8_bad_fcnt", {16'd0, fcnt_c8}, 32'd2);
        check("c8_done_twice", 32'(dn_c8), 32'd2);

        // 4: GENERATE backpressure, two back-to-back frames
        bp_on = 1'b1;
        fork
            while (bp_on) begin
                @(posedge clk);
                #1;
                or_g8 = ~or_g8;
            end
        join_none
        gen8_frame();
        gen8_frame();
        wait_drain();
        bp_on = 1'b0;
        @(posedge clk);
        #2;
        or_g8 = 1'b1;
        @(posedge clk);
        #1;
        check("g8_bp_crc_o", crc_g8, fcs_ref);
        check("g8_bp_done", 32'(dn_g8), 32'd3);
        check("g8_bp_fcnt", {16'd0, fcnt_g8}, 32'd3);

        // 5: CHECK saturation, then clear colliding with crc_done
        iv_c8 = 1'b1; il_c8 = 1'b1; id_c8 = 8'h00;
        for (int k = 0; k < 65540; k++) begin
            exp_c8.push_back(9'h100);
            @(posedge clk);
            #1;
        end
        check("c8_fcnt_sat", {16'd0, fcnt_c8}, 32'h0000_FFFF);
        check("c8_ecnt_sat", {16'd0, ecnt_c8}, 32'h0000_FFFF);
        exp_c8.push_back(9'h100);
        clr_c8 = 1'b1;
        @(negedge clk);
        check("c8_done_at_clr", {31'd0, done_c8}, 32'd1);
        @(posedge clk);
        #1;
        clr_c8 = 1'b0; iv_c8 = 1'b0; il_c8 = 1'b0;
        check("c8_fcnt_clr", {16'd0, fcnt_c8}, 32'd0);
        check("c8_ecnt_clr", {16'd0, ecnt_c8}, 32'd0);
        wait_drain();

        // 6: reset in the middle of a GENERATE frame, then rerun
        for (int i = 0; i < 3; i++) exp_g8.push_back({1'b0, msg[i]});
        for (int i = 0; i < 3; i++) send(0, msg[i], 1'b0);
        d0 = dn_g8;
        rst_n = 1'b0;
        #2;
        check("mid_rst_crc_o", crc_g8, 32'h0);
        check("mid_rst_done", {31'd0, done_g8}, 32'd0);
        check("mid_rst_fcnt", {16'd0, fcnt_g8}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_no_done", 32'(dn_g8), 32'(d0));
        gen8_frame();
        wait_drain();
        check("rerun_crc_o", crc_g8, fcs_ref);
        check("rerun_done", 32'(dn_g8), 32'(d0 + 1));
        check("rerun_fcnt", {16'd0, fcnt_g8}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
